alu_issue_ctrl: RTL

- Execute-stage issuer: the initiator side of the ALU interface (drives alu_src1, alu_src2, alu_ctrl; consumes alu_result, alu_zero).
- Accepts decoded operations from decode over a valid/ready handshake and decodes ALUOp/funct into the 4-bit ALU control code.
- Registers each operation into an issue stage that feeds the combinational ALU, then captures the ALU outputs into a writeback stage with branch resolution.
- Two-stage pipeline with full backpressure.

---
 rtl/alu_issue_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU issuer: decode, issue stage A, writeback stage B.
// Optional ALU_ILLEGAL_TRAP_EN flags illegal ops and zeroes their result.
module alu_issue_ctrl #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_aluop,
  input  logic [5:0]    in_funct,
  input  logic [DW-1:0] in_src1,
  input  logic [DW-1:0] in_src2,
  input  logic [RW-1:0] in_rd,
  output logic [DW-1:0] alu_src1,
  output logic [DW-1:0] alu_src2,
  output logic [3:0]    alu_ctrl,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_branch_taken,
  output logic          out_illegal
);

  logic [3:0]    dec_ctrl;
  logic          dec_branch;
  logic          dec_illegal;
  logic          a_valid;
  logic [RW-1:0] a_rd;
  logic          a_branch;
  logic          b_valid;
  logic          b_adv;
  logic          a_adv;
  logic          load_a;

  always_comb begin
    dec_ctrl    = 4'b0010;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    unique case (1'b1)
      (in_aluop == 2'b00): dec_ctrl = 4'b0010;
      (in_aluop == 2'b01): begin
        dec_ctrl   = 4'b0110;
        dec_branch = 1'b1;
      end
      (in_aluop == 2'b10): begin
        case (in_funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign b_adv     = !b_valid || out_ready;
  assign a_adv     = a_valid && b_adv;
  assign in_ready  = !a_valid || b_adv;
  assign load_a    = in_valid && in_ready;
  assign out_valid = b_valid;

`ifdef ALU_ILLEGAL_TRAP_EN
  logic a_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_illegal <= 1'b0;
    end else if (load_a) begin
      a_illegal <= dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_result       <= '0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else if (a_adv) begin
      out_result       <= a_illegal ? '0 : alu_result;
      out_branch_taken <= a_branch && alu_zero && !a_illegal;
      out_illegal      <= a_illegal;
    end
  end
`else
  // Illegal encodings already decode to add; nothing is flagged.
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign out_illegal    = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_result       <= '0;
      out_branch_taken <= 1'b0;
    end else if (a_adv) begin
      out_result       <= alu_result;
      out_branch_taken <= a_branch && alu_zero;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid  <= 1'b0;
      alu_ctrl <= 4'b0010;
      alu_src1 <= '0;
      alu_src2 <= '0;
      a_rd     <= '0;
      a_branch <= 1'b0;
    end else if (load_a) begin
      a_valid  <= 1'b1;
      alu_ctrl <= dec_ctrl;
      alu_src1 <= in_src1;
      alu_src2 <= in_src2;
      a_rd     <= in_rd;
      a_branch <= dec_branch;
    end else if (a_adv) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      out_rd  <= '0;
    end else if (a_adv) begin
      b_valid <= 1'b1;
      out_rd  <= a_rd;
    end else if (out_valid && out_ready) begin
      b_valid <= 1'b0;
    end
  end

endmodule
